// File: rtl/vred_pkg.sv
// Shared definitions for the AND/OR/XOR reduction sequencer.
// Holds the op and element-width codes, the sequencer state encoding and two
// helpers: elements per beat for a given sew, and the per-byte identity
// pattern used to pad tail elements.
package vred_pkg;

    localparam int unsigned OPSEL_W = 2;
    localparam int unsigned SEW_W   = 2;

    // Op codes; 2'b00 is out of range and passes through with zero padding.
    localparam logic [OPSEL_W-1:0] OP_AND = 2'b01;
    localparam logic [OPSEL_W-1:0] OP_OR  = 2'b10;
    localparam logic [OPSEL_W-1:0] OP_XOR = 2'b11;

    // Element width codes.
    localparam logic [SEW_W-1:0] SEW_8  = 2'd0;
    localparam logic [SEW_W-1:0] SEW_16 = 2'd1;
    localparam logic [SEW_W-1:0] SEW_32 = 2'd2;
    localparam logic [SEW_W-1:0] SEW_64 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACQ   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    // Number of elements that fit in one beat of beat_bytes bytes.
    function automatic int unsigned elems_per_beat(input int unsigned beat_bytes,
                                                   input logic [SEW_W-1:0] sew);
        int unsigned epb;
        case (sew)
            SEW_8:   epb = beat_bytes;
            SEW_16:  epb = beat_bytes >> 1;
            SEW_32:  epb = beat_bytes >> 2;
            SEW_64:  epb = beat_bytes >> 3;
            default: epb = beat_bytes;
        endcase
        return epb;
    endfunction

    // Identity byte pattern: all-ones for AND, zeros for OR/XOR and unknown ops.
    // Byte granularity works for every element width.
    function automatic logic [7:0] identity(input logic [OPSEL_W-1:0] op_sel);
        logic [7:0] id;
        case (op_sel)
            OP_AND:         id = 8'hFF;
            OP_OR, OP_XOR:  id = 8'h00;
            default:        id = 8'h00;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/vred_tail_pad.sv
// Combinational tail padding for the last beat of a reduction.
// Ports:
//   data_i  - raw beat from the register file
//   last_i  - beat is the final one of the command
//   tail_i  - number of live elements in the final beat (1..epb)
//   sew_i   - element width code
//   op_i    - op code selecting the pad identity
//   data_c  - beat with elements at index >= tail_i replaced by the identity
module vred_tail_pad
    import vred_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned VL_WIDTH    = 11,
    parameter int unsigned SEW_WIDTH   = 2,
    parameter int unsigned OPSEL_WIDTH = 2
) (
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   last_i,
    input  logic [VL_WIDTH-1:0]    tail_i,
    input  logic [SEW_WIDTH-1:0]   sew_i,
    input  logic [OPSEL_WIDTH-1:0] op_i,
    output logic [DATA_WIDTH-1:0]  data_c
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    // Byte b belongs to element (b >> sew); pad it when that element is past the tail.
    always_comb begin
        data_c = data_i;
        if (last_i) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if ((b >> sew_i) >= 32'(tail_i)) begin
                    data_c[b*8 +: 8] = identity(2'(op_i));
                end
            end
        end
    end

endmodule

// File: rtl/vred_andorxor_seq.sv
// Sequencer for the AND/OR/XOR reduction pipeline.
// Accepts one command, locks the VRF read port, streams ceil(vl/epb)
// contiguous beats with start/end flags into the reduction unit (tail padded
// with the op identity), waits for the unit's result and pulses done.
// Ports:
//   clk, rst                         - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_*       - command handshake and fields
//   rd_req/rd_gnt                    - VRF read-port lock request / grant
//   rd_en/rd_addr/rd_data            - read strobe, row, data (1 cycle later)
//   red_vec0/red_valid/red_start/red_end/red_opSel/red_sew/red_addr - beat out
//   red_out_valid                    - result valid from the reduction unit
//   done                             - one-cycle completion pulse
// Optional: define VRED_SEQ_PERF_EN to add perf_cmds, perf_beats and
// perf_gnt_wait saturating 32-bit counters.
module vred_andorxor_seq
    import vred_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned VL_WIDTH    = 11,
    parameter int unsigned OPSEL_WIDTH = 2,
    parameter int unsigned SEW_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_WIDTH-1:0]  cmd_src,
    input  logic [ADDR_WIDTH-1:0]  cmd_dst,
    input  logic [VL_WIDTH-1:0]    cmd_vl,
    input  logic [SEW_WIDTH-1:0]   cmd_sew,
    input  logic [OPSEL_WIDTH-1:0] cmd_opSel,
    output logic                   rd_req,
    input  logic                   rd_gnt,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DATA_WIDTH-1:0]  red_vec0,
    output logic                   red_valid,
    output logic                   red_start,
    output logic                   red_end,
    output logic [OPSEL_WIDTH-1:0] red_opSel,
    output logic [SEW_WIDTH-1:0]   red_sew,
    output logic [ADDR_WIDTH-1:0]  red_addr,
    input  logic                   red_out_valid,
    output logic                   done
`ifdef VRED_SEQ_PERF_EN
    ,
    output logic [31:0]            perf_cmds,
    output logic [31:0]            perf_beats,
    output logic [31:0]            perf_gnt_wait
`endif
);

    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
    localparam int unsigned BEAT_LG    = $clog2(BEAT_BYTES);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  src_q, src_d;
    logic [ADDR_WIDTH-1:0]  dst_q, dst_d;
    logic [OPSEL_WIDTH-1:0] op_q, op_d;
    logic [SEW_WIDTH-1:0]   sew_q, sew_d;
    logic [VL_WIDTH-1:0]    nbeats_q, nbeats_d;
    logic [VL_WIDTH-1:0]    tail_q, tail_d;
    logic [VL_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;

    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rd_req_q, rd_req_d;
    logic                   rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic                   red_valid_q, red_valid_d;
    logic                   red_start_q, red_start_d;
    logic                   red_end_q, red_end_d;
    logic [OPSEL_WIDTH-1:0] red_opsel_q, red_opsel_d;
    logic [SEW_WIDTH-1:0]   red_sew_q, red_sew_d;
    logic [ADDR_WIDTH-1:0]  red_addr_q, red_addr_d;
    logic                   done_q, done_d;

    int unsigned            epb_c;
    int unsigned            lg_c;
    logic                   issuing_c;
    logic                   last_strobe_c;
    logic [DATA_WIDTH-1:0]  pad_data_c;

    // Beat geometry of the incoming command; epb is a power of two so shift/mask suffice.
    always_comb begin
        epb_c = elems_per_beat(BEAT_BYTES, 2'(cmd_sew));
        lg_c  = BEAT_LG - 32'(cmd_sew);
    end

    assign issuing_c     = (state_q == ST_ISSUE);
    assign last_strobe_c = issuing_c && (beat_cnt_q == nbeats_q - VL_WIDTH'(1));

    // Next state, latched command and registered outputs.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        op_d       = op_q;
        sew_d      = sew_q;
        nbeats_d   = nbeats_q;
        tail_d     = tail_q;
        beat_cnt_d = beat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    src_d    = cmd_src;
                    dst_d    = cmd_dst;
                    op_d     = cmd_opSel;
                    sew_d    = cmd_sew;
                    nbeats_d = VL_WIDTH'((32'(cmd_vl) + epb_c - 32'd1) >> lg_c);
                    tail_d   = VL_WIDTH'(((32'(cmd_vl) - 32'd1) & (epb_c - 32'd1)) + 32'd1);
                    state_d  = (cmd_vl == '0) ? ST_FIN : ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (rd_gnt) begin
                    beat_cnt_d = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                beat_cnt_d = beat_cnt_q + VL_WIDTH'(1);
                if (last_strobe_c) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (red_out_valid) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake and read-port outputs follow the state being entered.
        cmd_ready_d = (state_d == ST_IDLE);
        rd_req_d    = (state_d == ST_ACQ) || (state_d == ST_ISSUE);
        rd_en_d     = (state_d == ST_ISSUE);
        done_d      = (state_d == ST_FIN);
        rd_addr_d   = '0;
        if (state_d == ST_ISSUE) begin
            rd_addr_d = (state_q == ST_ACQ) ? src_q : rd_addr_q + ADDR_WIDTH'(1);
        end

        // Beat qualifiers trail the strobe by one cycle, lining up with rd_data.
        red_valid_d = issuing_c;
        red_start_d = issuing_c && (beat_cnt_q == '0);
        red_end_d   = last_strobe_c;
        red_opsel_d = issuing_c ? op_q  : '0;
        red_sew_d   = issuing_c ? sew_q : '0;
        red_addr_d  = issuing_c ? dst_q : '0;
    end

    // State, command and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            op_q        <= '0;
            sew_q       <= '0;
            nbeats_q    <= '0;
            tail_q      <= '0;
            beat_cnt_q  <= '0;
            cmd_ready_q <= 1'b1;
            rd_req_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            red_valid_q <= 1'b0;
            red_start_q <= 1'b0;
            red_end_q   <= 1'b0;
            red_opsel_q <= '0;
            red_sew_q   <= '0;
            red_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            op_q        <= op_d;
            sew_q       <= sew_d;
            nbeats_q    <= nbeats_d;
            tail_q      <= tail_d;
            beat_cnt_q  <= beat_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rd_req_q    <= rd_req_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            red_valid_q <= red_valid_d;
            red_start_q <= red_start_d;
            red_end_q   <= red_end_d;
            red_opsel_q <= red_opsel_d;
            red_sew_q   <= red_sew_d;
            red_addr_q  <= red_addr_d;
            done_q      <= done_d;
        end
    end

    vred_tail_pad #(
        .DATA_WIDTH  (DATA_WIDTH),
        .VL_WIDTH    (VL_WIDTH),
        .SEW_WIDTH   (SEW_WIDTH),
        .OPSEL_WIDTH (OPSEL_WIDTH)
    ) u_tail_pad (
        .data_i (rd_data),
        .last_i (red_end_q),
        .tail_i (tail_q),
        .sew_i  (sew_q),
        .op_i   (op_q),
        .data_c (pad_data_c)
    );

    // rd_data arrives in the beat cycle; gating keeps the bus at zero outside beats and in reset.
    assign red_vec0  = red_valid_q ? pad_data_c : '0;

    assign cmd_ready = cmd_ready_q;
    assign rd_req    = rd_req_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign red_valid = red_valid_q;
    assign red_start = red_start_q;
    assign red_end   = red_end_q;
    assign red_opSel = red_opsel_q;
    assign red_sew   = red_sew_q;
    assign red_addr  = red_addr_q;
    assign done      = done_q;

`ifdef VRED_SEQ_PERF_EN
    logic [31:0] perf_cmds_q, perf_cmds_d;
    logic [31:0] perf_beats_q, perf_beats_d;
    logic [31:0] perf_gnt_wait_q, perf_gnt_wait_d;

    // Saturating event counters: completions, strobes issued, grant-wait cycles.
    always_comb begin
        perf_cmds_d     = perf_cmds_q;
        perf_beats_d    = perf_beats_q;
        perf_gnt_wait_d = perf_gnt_wait_q;
        if ((state_q == ST_FIN) && (perf_cmds_q != '1)) begin
            perf_cmds_d = perf_cmds_q + 32'd1;
        end
        if (issuing_c && (perf_beats_q != '1)) begin
            perf_beats_d = perf_beats_q + 32'd1;
        end
        if ((state_q == ST_ACQ) && (perf_gnt_wait_q != '1)) begin
            perf_gnt_wait_d = perf_gnt_wait_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cmds_q     <= '0;
            perf_beats_q    <= '0;
            perf_gnt_wait_q <= '0;
        end else begin
            perf_cmds_q     <= perf_cmds_d;
            perf_beats_q    <= perf_beats_d;
            perf_gnt_wait_q <= perf_gnt_wait_d;
        end
    end

    assign perf_cmds     = perf_cmds_q;
    assign perf_beats    = perf_beats_q;
    assign perf_gnt_wait = perf_gnt_wait_q;
`endif

endmodule

// File: tb/tb_vred_andorxor_seq.sv
// Bench for vred_andorxor_seq: VRF responder with programmable grant delay,
// reduction-unit model returning a result 6 cycles after red_end, and a
// scoreboard of expected beats and read addresses.
module tb_vred_andorxor_seq;
    import vred_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_src = '0;
    logic [31:0] cmd_dst = '0;
    logic [10:0] cmd_vl = '0;
    logic [1:0]  cmd_sew = '0;
    logic [1:0]  cmd_opSel = '0;
    logic        rd_req;
    logic        rd_gnt;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [63:0] rd_data = '0;
    logic [63:0] red_vec0;
    logic        red_valid, red_start, red_end;
    logic [1:0]  red_opSel, red_sew;
    logic [31:0] red_addr;
    logic        red_out_valid;
    logic        done;

    vred_andorxor_seq dut (
        .clk (clk), .rst (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_src (cmd_src), .cmd_dst (cmd_dst), .cmd_vl (cmd_vl),
        .cmd_sew (cmd_sew), .cmd_opSel (cmd_opSel),
        .rd_req (rd_req), .rd_gnt (rd_gnt), .rd_en (rd_en),
        .rd_addr (rd_addr), .rd_data (rd_data),
        .red_vec0 (red_vec0), .red_valid (red_valid), .red_start (red_start),
        .red_end (red_end), .red_opSel (red_opSel), .red_sew (red_sew),
        .red_addr (red_addr), .red_out_valid (red_out_valid), .done (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        start;
        logic        last;
        logic [1:0]  op;
        logic [1:0]  sew;
        logic [31:0] addr;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] addr_q[$];
    logic [63:0] vrf[256];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          beats_seen = 0;
    int          req_cycles = 0;
    int          acq_cycles = 0;
    int          rov_cycle = -100;
    bit          in_cmd = 1'b0;
    int          gnt_delay = 0;
    int          req_cnt = 0;
    int          red_cd = 0;

    always @(posedge clk) cyc++;

    // VRF: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) rd_data <= rd_en ? vrf[rd_addr[7:0]] : 64'hDEAD_BEEF_0BAD_F00D;

    // Grant arrives gnt_delay cycles after rd_req rises and holds while requested.
    always @(posedge clk or negedge rst) begin
        if (!rst)         req_cnt <= 0;
        else if (!rd_req) req_cnt <= 0;
        else              req_cnt <= req_cnt + 1;
    end
    assign rd_gnt = rd_req && (req_cnt >= gnt_delay);

    // Reduction unit: result valid 6 cycles after the red_end beat.
    always @(posedge clk or negedge rst) begin
        if (!rst)                       red_cd <= 0;
        else if (red_valid && red_end)  red_cd <= 6;
        else if (red_cd != 0)           red_cd <= red_cd - 1;
    end
    assign red_out_valid = (red_cd == 1);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard / protocol monitor, sampling mid-cycle.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            exp_q.delete();
            addr_q.delete();
            in_cmd = 1'b0;
        end else begin
            if (rd_req) req_cycles++;
            if (rd_req && !rd_en) acq_cycles++;
            if (rd_en) begin
                if (addr_q.size() == 0) check("rd_en_unexpected", 64'(rd_en), 64'd0);
                else check("rd_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
            end
            if (in_cmd) check("beat_contiguous", 64'(red_valid), 64'd1);
            if (red_valid) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 64'(red_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("red_vec0", red_vec0, e.data);
                    check("red_ctl", 64'({red_start, red_end, red_opSel, red_sew, red_addr}),
                          64'({e.start, e.last, e.op, e.sew, e.addr}));
                end
                if (red_start) in_cmd = 1'b1;
                if (red_end)   in_cmd = 1'b0;
            end
            if (red_out_valid) rov_cycle = cyc;
            if (done) check("ready_done_overlap", 64'(cmd_ready), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent model of the expected beat stream for one command.
    task automatic push_expect(input logic [31:0] src, input logic [31:0] dst,
                               input int vl, input int sew, input logic [1:0] op);
        int          epb, w, nb, tail;
        beat_t       b;
        logic [63:0] d;
        epb = 8 >> sew;
        w   = 8 << sew;
        if (vl == 0) return;
        nb   = (vl + epb - 1) / epb;
        tail = vl - (nb - 1) * epb;
        for (int k = 0; k < nb; k++) begin
            d = vrf[8'(src + 32'(k))];
            if (k == nb - 1) begin
                for (int j = 0; j < 64; j++) begin
                    if (j / w >= tail) d[j] = (op == OP_AND);
                end
            end
            b.data  = d;
            b.start = (k == 0);
            b.last  = (k == nb - 1);
            b.op    = op;
            b.sew   = 2'(sew);
            b.addr  = dst;
            exp_q.push_back(b);
            addr_q.push_back(src + 32'(k));
        end
    endtask

    task automatic drive_cmd(input logic [31:0] src, input logic [31:0] dst,
                             input int vl, input int sew, input logic [1:0] op);
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_vl    = 11'(vl);
        cmd_sew   = 2'(sew);
        cmd_opSel = op;
        push_expect(src, dst, vl, sew, op);
        cmd_valid = 1'b1;
    endtask

    // Wait for cmd_ready, let the accepting edge pass; acc = cycle of acceptance.
    task automatic accept(input bit keep, output int acc);
        for (int n = 0; n < 200 && !cmd_ready; n++) tick();
        if (!cmd_ready) check("accept_timeout", 64'(cmd_ready), 64'd1);
        acc = cyc;
        tick();
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        for (int n = 0; n < 300 && !done; n++) tick();
        if (!done) check("done_timeout", 64'(done), 64'd1);
        dcyc = cyc;
        tick();
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        int acc, acc2, dcyc, dcyc2, b0, r0, a0;
        for (int i = 0; i < 256; i++)
            vrf[i] = {8'(i), 8'h3C, 16'(i * 7 + 1), 32'hC0DE_0000 | 32'(i)};
        vrf[8'h20] = 64'hFFFF_FFFF_FFFF_FFFF;

        // Reset state.
        tick(); tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rd", 64'({rd_req, rd_en, rd_addr}), 64'd0);
        check("rst_red_ctl", 64'({red_valid, red_start, red_end, red_opSel, red_sew, red_addr}), 64'd0);
        check("rst_red_vec0", red_vec0, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        tick();

        // One beat, AND, all-ones data, immediate grant.
        gnt_delay = 0;
        b0 = beats_seen; a0 = acq_cycles;
        drive_cmd(32'h20, 32'hA000, 8, 0, OP_AND);
        accept(1'b0, acc);
        wait_done(dcyc);
        check("t1_beats", 64'(beats_seen - b0), 64'd1);
        check("t1_acq_cycles", 64'(acq_cycles - a0), 64'd1);
        check("t1_done_after_result", 64'(dcyc), 64'(rov_cycle + 1));

        // Two beats, OR, 16-bit elements, tail of one element.
        b0 = beats_seen;
        drive_cmd(32'h10, 32'hB000, 5, 1, OP_OR);
        accept(1'b0, acc);
        wait_done(dcyc);
        check("t2_beats", 64'(beats_seen - b0), 64'd2);
        check("t2_done_after_result", 64'(dcyc), 64'(rov_cycle + 1));

        // Two beats, AND, 32-bit elements, grant four cycles into ACQ.
        gnt_delay = 3;
        b0 = beats_seen; a0 = acq_cycles;
        drive_cmd(32'h30, 32'hC000, 3, 2, OP_AND);
        accept(1'b0, acc);
        wait_done(dcyc);
        check("t3_beats", 64'(beats_seen - b0), 64'd2);
        check("t3_acq_cycles", 64'(acq_cycles - a0), 64'd4);
        gnt_delay = 0;

        // vl == 0: no read traffic, straight to done.
        b0 = beats_seen; r0 = req_cycles;
        drive_cmd(32'h44, 32'hD000, 0, 0, OP_XOR);
        accept(1'b0, acc);
        check("t4_done_now", 64'(done), 64'd1);
        wait_done(dcyc);
        check("t4_done_cycle", 64'(dcyc), 64'(acc + 1));
        check("t4_no_rd_req", 64'(req_cycles - r0), 64'd0);
        check("t4_no_beats", 64'(beats_seen - b0), 64'd0);

        // Abort with reset during the second of four strobes.
        drive_cmd(32'h40, 32'hD100, 32, 0, OP_XOR);
        accept(1'b0, acc);
        for (int n = 0; n < 50 && !(rd_en && rd_addr == 32'h41); n++) tick();
        check("t5_reached_beat2", 64'(rd_en && rd_addr == 32'h41), 64'd1);
        rst = 1'b0;
        #1;
        check("t5_abort_rd", 64'({rd_req, rd_en, rd_addr}), 64'd0);
        check("t5_abort_red_ctl", 64'({red_valid, red_start, red_end, red_opSel, red_sew, red_addr}), 64'd0);
        check("t5_abort_red_vec0", red_vec0, 64'd0);
        check("t5_abort_ready", 64'(cmd_ready), 64'd1);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("t5_no_done_in_rst", 64'(done), 64'd0);
        end
        rst = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            check("t5_no_done_after", 64'(done), 64'd0);
        end
        b0 = beats_seen;
        drive_cmd(32'h50, 32'hE000, 10, 1, OP_AND);
        accept(1'b0, acc);
        wait_done(dcyc);
        check("t5_next_beats", 64'(beats_seen - b0), 64'd3);

        // Back-to-back with cmd_valid held: second accepted only after done.
        b0 = beats_seen;
        drive_cmd(32'h60, 32'hF000, 3, 3, OP_OR);
        accept(1'b1, acc);
        drive_cmd(32'h70, 32'hF100, 7, 0, OP_XOR);
        wait_done(dcyc);
        accept(1'b0, acc2);
        check("t6_accept_after_done", 64'(acc2), 64'(dcyc + 1));
        wait_done(dcyc2);
        check("t6_beats", 64'(beats_seen - b0), 64'd4);
        check("t6_scoreboard_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
